// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER fetch front end.
package otter_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/otter_sync_fifo.sv
// Synchronous FIFO with clear; a pop in the same cycle frees a slot for a push
// into a full FIFO.
module otter_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER instruction fetch: PC ownership, credit-limited in-order fetch,
// stale-response dropping after redirect, and the IF_DE buffer.
module otter_fetch_stage
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        de_ready,
  output logic        de_valid,
  output logic [31:0] de_pc,
  output logic [31:0] de_ir
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;
  logic             accept;
  logic [31:0]      target_pc;
  fetch_entry_t     push_entry, head_entry;

  assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req   = !RESET && !redirect &&
                      ((SUM_W'(outst_q) + SUM_W'(fifo_count)) < SUM_W'(DEPTH));
  assign imem_addr  = fetch_pc_q;
  assign accept     = imem_req && imem_ready;
  assign push_entry = '{pc: resp_pc_q, ir: imem_rdata};

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= FS_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_RUN:   if (redirect && (outst_d != '0)) state_d = FS_DRAIN;
      FS_DRAIN: if (drop_d == '0) state_d = FS_RUN;
      default:  state_d = FS_RUN;
    endcase
  end

  // Redirect overrides every same-cycle push, pop and PC advance.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    outst_d    = outst_q + CNT_W'(accept) - CNT_W'(imem_rvalid);
    if (redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_d     = outst_d;
    end else begin
      fifo_pop = de_ready && de_valid;
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rvalid) begin
        if (state_q == FS_DRAIN) begin
          drop_d = drop_q - CNT_W'(1);
        end else begin
          fifo_push = !fifo_full || fifo_pop;
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc_q <= RESET_VEC;
      resp_pc_q  <= RESET_VEC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  otter_sync_fifo #(
    .WIDTH(FETCH_ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .push_i (fifo_push),
    .wdata_i(push_entry),
    .pop_i  (fifo_pop),
    .clear_i(redirect),
    .rdata_o(head_entry),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign de_valid = !fifo_empty;
  assign de_pc    = head_entry.pc;
  assign de_ir    = de_valid ? head_entry.ir : NOP_INSTR;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Scoreboard bench for otter_fetch_stage: a latency-randomised memory model,
// an expected-instruction-stream queue and an independent output monitor.
module tb_otter_fetch_stage;
  import otter_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RVEC  = 32'h0000_0000;

  logic        CLK, RESET;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect, de_ready, de_valid;
  logic [31:0] redirect_pc, de_pc, de_ir;

  otter_fetch_stage #(.RESET_VEC(RVEC), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .de_ready(de_ready), .de_valid(de_valid), .de_pc(de_pc), .de_ir(de_ir)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } pend_t;

  pend_t        pend_q[$];   // requests accepted by memory, awaiting response
  fetch_entry_t exp_q[$];    // expected decode stream: accepted, not stale, not consumed
  int           delivered;   // expected entries already visible to decode
  int unsigned  cyc;
  int           n_checks, n_pass, pops;
  logic [31:0]  model_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One bench cycle: drive at negedge, check issue at +1, retire model at +3.
  task automatic step(input bit rst, input bit rdy, input bit drdy, input bit redir,
                      input logic [31:0] rpc, input int unsigned lat);
    bit resp_now;
    bit req_exp;
    int stale_n;
    @(negedge CLK);
    cyc++;
    RESET       = rst;
    imem_ready  = rdy;
    de_ready    = drdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (rst) pend_q.delete();
    resp_now    = !rst && (pend_q.size() != 0) && (pend_q[0].due <= cyc);
    imem_rvalid = resp_now;
    imem_rdata  = resp_now ? mem_word(pend_q[0].addr) : $urandom();
    #1;
    stale_n = 0;
    foreach (pend_q[i]) if (pend_q[i].stale) stale_n++;
    req_exp = !rst && !redir && ((stale_n + exp_q.size()) < DEPTH);
    check("imem_req", 32'(imem_req), 32'(req_exp));
    if (imem_req && imem_ready) begin
      check("imem_addr", imem_addr, model_pc);
      pend_q.push_back('{addr: imem_addr, due: cyc + lat, stale: 1'b0});
      exp_q.push_back('{pc: model_pc, ir: mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
    #2;
    if (rst) begin
      exp_q.delete();
      delivered = 0;
      model_pc  = RVEC;
    end else if (redir) begin
      exp_q.delete();
      delivered = 0;
      model_pc  = rpc & 32'hFFFF_FFFC;
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      if (resp_now) void'(pend_q.pop_front());
    end else if (resp_now) begin
      if (!pend_q[0].stale) delivered++;
      void'(pend_q.pop_front());
    end
  endtask

  // Monitor: compares what decode sees against the head of the expected stream.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      check("de_valid", 32'(de_valid), 32'(delivered != 0));
      if (de_valid && exp_q.size() != 0) begin
        check("de_pc", de_pc, exp_q[0].pc);
        check("de_ir", de_ir, exp_q[0].ir);
      end else if (!de_valid) begin
        check("de_ir_nop", de_ir, NOP_INSTR);
      end
      if (de_valid && de_ready && !redirect && !RESET && delivered != 0) begin
        void'(exp_q.pop_front());
        delivered--;
        pops++;
      end
    end
  end

  initial begin
    bit          r_rst, r_rdy, r_drdy, r_redir;
    logic [31:0] r_pc;
    n_checks = 0; n_pass = 0; pops = 0; cyc = 0; delivered = 0;
    model_pc = RVEC;
    RESET = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; de_ready = 1'b0;

    repeat (3)  step(1, 1, 1, 0, 32'h0, 1);
    repeat (20) step(0, 1, 1, 0, 32'h0, 1);          // streaming, latency 1
    repeat (10) step(0, 1, 0, 0, 32'h0, 1);          // decode stalled
    repeat (10) step(0, 1, 1, 0, 32'h0, 1);
    step(0, 1, 1, 1, 32'h0000_0200, 1);              // redirect with rvalid and pop
    repeat (6)  step(0, 1, 1, 0, 32'h0, 1);

    step(1, 1, 1, 0, 32'h0, 3);
    repeat (2)  step(0, 1, 1, 0, 32'h0, 3);          // two in flight
    step(0, 1, 1, 1, 32'h0000_0103, 3);
    repeat (12) step(0, 1, 1, 0, 32'h0, 3);

    repeat (6)  step(0, 1, 0, 0, 32'h0, 2);          // fill buffer
    step(1, 1, 1, 0, 32'h0, 1);                      // reset mid-operation
    repeat (8)  step(0, 1, 1, 0, 32'h0, 1);

    step(0, 1, 1, 1, 32'hFFFF_FFF8, 1);              // address wrap
    repeat (10) step(0, 1, 1, 0, 32'h0, 1);

    repeat (3000) begin
      r_rst   = ($urandom_range(0, 299) == 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_drdy  = ($urandom_range(0, 3) != 0);
      r_redir = ($urandom_range(0, 15) == 0);
      r_pc    = $urandom();
      if ($urandom_range(0, 7) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
      step(r_rst, r_rdy, r_drdy, r_redir, r_pc, $urandom_range(1, 4));
    end
    step(0, 1, 1, 0, 32'h0, 1);

    check("progress", 32'(pops >= 200), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
